// File: rtl/uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampler
//
// UART receive stage. Samples the asynchronous serial line on oversample
// ticks taken from the baud generator's clock, finds each bit centre and
// assembles N-data-bit frames LSB first. The received word is handed to
// the bus side through a valid/ready holding register.
//
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit and to add the parity_err port.
//
// Parameters
//   DATA_BITS     data bits per frame (5..9)
//   OVERSAMPLING  oversample ticks per bit period (even, >= 4)
//
// Ports
//   clk          system clock, all logic in this domain
//   rst_n        asynchronous active-low reset
//   baud_clk     oversample clock; each synced rising edge is one tick
//   rx           serial line, idle high, asynchronous to clk
//   rx_data      received word holding register
//   rx_valid     rx_data holds an unread word
//   rx_ready     consumer takes rx_data when rx_valid && rx_ready
//   frame_err    1-cycle pulse: stop bit sampled low
//   overrun_err  1-cycle pulse: word completed while previous one unread
//   parity_err   1-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
//   busy         receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_oversampler #(
   parameter int DATA_BITS    = 8,
   parameter int OVERSAMPLING = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_clk,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLING);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t               state, state_nxt;
   logic                 rx_s1, rx_s2, rx_prev;
   logic                 bd_s1, bd_s2, bd_prev;
   logic                 rx_fall, tick;
   logic                 smp_half, smp_full;
   logic                 data_shift, complete;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
   logic                 par_smp;
   logic                 par_bit;
`endif

   // Synchronizers preset to 1: an idle line and a "high" baud clock, so
   // leaving reset never manufactures a falling edge or a spurious tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {rx_s1, rx_s2, rx_prev} <= 3'b111;
         {bd_s1, bd_s2, bd_prev} <= 3'b111;
      end else begin
         {rx_s1, rx_s2, rx_prev} <= {rx, rx_s1, rx_s2};
         {bd_s1, bd_s2, bd_prev} <= {baud_clk, bd_s1, bd_s2};
      end
   end

   assign rx_fall  = rx_prev & ~rx_s2;
   assign tick     = bd_s2 & ~bd_prev;
   // Half-bit point for start validation, full-bit point for every later
   // bit: the start check lands mid-bit, so each later sample does too.
   assign smp_half = tick && (cnt == CNT_HALF);
   assign smp_full = tick && (cnt == CNT_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (rx_fall) state_nxt = S_START;
         S_START:  if (smp_half) state_nxt = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:   if (smp_full && bit_idx == IDX_LAST)
`ifdef UART_RX_PARITY_EN
                      state_nxt = S_PARITY;
`else
                      state_nxt = S_STOP;
`endif
         S_PARITY: if (smp_full) state_nxt = S_STOP;
         S_STOP:   if (smp_full) state_nxt = rx_s2 ? S_IDLE : S_BREAK;
         // A held-low line must return high before a new start can count.
         S_BREAK:  if (rx_s2) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath strobes ----------------
   always_comb begin
      busy       = (state != S_IDLE);
      data_shift = (state == S_DATA) && smp_full;
      complete   = (state == S_STOP) && smp_full;
`ifdef UART_RX_PARITY_EN
      par_smp    = (state == S_PARITY) && smp_full;
`endif
   end

   // Tick counter restarts on every state change so each state measures
   // its own sample point from its entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (state == S_START) bit_idx <= '0;
         else if (data_shift) begin
            shreg[bit_idx] <= rx_s2;
            bit_idx        <= bit_idx + IDX_W'(1);
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       par_bit <= 1'b0;
      else if (par_smp) par_bit <= rx_s2;
   end
`endif

   // Holding register. A completion always loads, even with a bad stop
   // bit, and wins over a same-cycle accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
         if (complete) begin
            rx_data     <= shreg;
            rx_valid    <= 1'b1;
            frame_err   <= ~rx_s2;
            overrun_err <= rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err  <= ^{shreg, par_bit};
`endif
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
- UART receive stage sitting directly downstream of the baud clock generator.
- Samples the asynchronous serial line rx on oversample ticks derived from baud_clk.
- Locates each bit centre and assembles 8N1 frames, LSB first.
- Presents each received byte through a valid/ready holding register to the bus-side UART logic; reports framing errors and overrun.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLING, 16, oversample ticks per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock; all logic in this domain.
- rst_n  input  1  asynchronous active-low reset.
- baud_clk  input  1  oversample clock from the baud generator, sampled in clk domain; each rising edge is one oversample tick.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  received byte holding register.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: new byte completed while rx_valid still high.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset: all outputs 0 (rx_data = 0); FSM to IDLE; synchronizers preset to 1 (line idle); tick and bit counters cleared.
- Reset asserted mid-frame aborts the frame with no flags and no data update.
- rx passes a 2-flop synchronizer.
- baud_clk passes a 2-flop synchronizer plus an edge detector; tick = 1-cycle pulse on the synced rising edge.
- Tick counter is log2(OVERSAMPLING) bits and advances only on tick; it clears on every state entry.
- IDLE:
  - On synced rx falling edge (prev 1, now 0) -> START, tick counter = 0.
- START:
  - On tick with count == OVERSAMPLING/2-1, sample rx.
  - rx = 0 -> DATA, bit index = 0, tick counter = 0.
  - rx = 1 -> false start, back to IDLE with no flags.
- DATA:
  - On tick with count == OVERSAMPLING-1, shift rx into the shift register at bit[index] (LSB first), index++.
  - After DATA_BITS samples -> STOP (or PARITY when the macro is defined).
- STOP:
  - At count == OVERSAMPLING-1, sample rx.
  - Complete the frame in that same cycle (see frame completion).
  - rx = 1 -> IDLE; back-to-back frames are supported.
  - rx = 0 -> pulse frame_err, go to BREAK.
- BREAK:
  - Wait for synced rx == 1, then IDLE. No falling-edge detection while in BREAK.
- Frame completion:
  - rx_data <= shift register; rx_valid <= 1. This happens on framing error too.
  - If rx_valid was already 1 and not being accepted that cycle: pulse overrun_err, and the old byte is overwritten.
  - Completion with a simultaneous accept is not an overrun.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready unless a new completion occurs in that same cycle, which wins (rx_valid stays 1 with new data).
  - rx_data is stable while rx_valid = 1 and no completion occurs.
- Latency: rx_valid rises 1 clk after the tick that samples the stop bit.
- busy = (state != IDLE).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; one bit sampled at count == OVERSAMPLING-1.
  - Even parity over data bits plus the parity bit.
  - Mismatch gives a one-cycle parity_err output pulse coincident with frame completion.
  - Port parity_err exists only when defined.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Test Plan:
- Drive 0xA5 (LSB first, start 0, stop 1) at 16 ticks/bit, rx_ready = 0 -> rx_valid rises 1 clk after stop-sample tick, rx_data = 0xA5, frame_err = 0, overrun_err = 0; rx_ready = 1 for one cycle -> rx_valid = 0 next cycle.
- rx low for only 4 ticks then high -> FSM returns to IDLE, busy drops, no rx_valid, no flags.
- Frame 0x3C with stop bit held low for 3 bit times then released -> rx_data = 0x3C, rx_valid = 1, frame_err pulses once; no new frame is detected until rx returns high.
- Two back-to-back frames 0x11, 0x22 with rx_ready held 0 -> second completion pulses overrun_err once, rx_data = 0x22, rx_valid stays 1.
- Assert rst_n = 0 during bit 3 of a frame -> all outputs 0 immediately; after release, next frame 0x5A is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulses, rx_data = 0x07; 0x07 with parity bit 1 -> no parity_err.
